multi_digit_7seg_scan: RTL

//   Time-multiplexed scanner for an N-digit 7-segment display. Consumes the
//   per-digit segment patterns produced by the single-digit driver stage and

---
 rtl/multi_digit_7seg_scan.sv | 122 ++++++++++++
 1 files changed

// File: rtl/multi_digit_7seg_scan.sv
// Time-multiplexed scanner for an N-digit 7-segment display.
// Each digit owns one slot of CLK_DIV cycles: a dark interval of DEAD_CYCLES
// against ghosting, then the pattern captured at the start of the lit phase.
// All outputs come from registers; nothing from the inputs reaches a pin
// without passing through a flop.
module multi_digit_7seg_scan #(
    parameter int N_DIGITS         = 4,
    parameter int CLK_DIV          = 50000,
    parameter int DEAD_CYCLES      = 16,
    parameter int DISPLAY_TYPE     = 0,
    parameter int DIGIT_ACTIVE_LOW = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [8*N_DIGITS-1:0] seg7_i,
    output logic [7:0]            seg7_o,
    output logic [N_DIGITS-1:0]   dig_o,
    output logic                  frame_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0]       CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]       CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF  = (DISPLAY_TYPE != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF  = (DIGIT_ACTIVE_LOW != 0) ?
                                               {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_ACTIVE
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [7:0]          r_seg;
    logic [N_DIGITS-1:0] r_dig;
    logic                r_frame;

    state_t              w_stateNext;
    logic [CW-1:0]       w_cntNext;
    logic [IW-1:0]       w_idxNext;
    logic                w_enterActive;
    logic                w_frameNext;
    logic [N_DIGITS-1:0] w_onehot;
    logic [N_DIGITS-1:0] w_digOn;
    logic [7:0]          w_pattern;

    // Next slot position: disable forces idle, a slot end wraps the counter
    // and moves on to the next digit, otherwise the counter walks the slot.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_idxNext   = r_idx;
        if (!en_i) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
            w_idxNext   = '0;
        end else if (r_state == ST_IDLE) begin
            w_cntNext   = '0;
            w_idxNext   = '0;
            w_stateNext = (DEAD_CYCLES == 0) ? ST_ACTIVE : ST_DEAD;
        end else if (r_cnt == CNT_LAST) begin
            w_cntNext   = '0;
            w_idxNext   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            w_stateNext = (DEAD_CYCLES == 0) ? ST_ACTIVE : ST_DEAD;
        end else begin
            w_cntNext   = r_cnt + 1'b1;
            w_stateNext = (w_cntNext >= CNT_DEAD) ? ST_ACTIVE : ST_DEAD;
        end
    end

    // Digit enable pattern, capture point and frame marker for the coming cycle.
    // A pattern is grabbed only when a lit phase begins, so mid-slot input
    // changes never tear the digit currently shown.
    always_comb begin
        w_onehot            = '0;
        w_onehot[w_idxNext] = 1'b1;
        w_digOn             = (DIGIT_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
        w_pattern           = seg7_i[8*w_idxNext +: 8];
        w_enterActive       = (w_stateNext == ST_ACTIVE) &&
                              ((r_state != ST_ACTIVE) || (r_cnt == CNT_LAST));
        w_frameNext         = (w_stateNext != ST_IDLE) &&
                              (w_cntNext == '0) && (w_idxNext == '0);
    end

    // Scan state machine with registered display outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_seg   <= SEG_OFF;
            r_dig   <= DIG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_idx   <= w_idxNext;
            r_frame <= w_frameNext;
            if (w_stateNext == ST_ACTIVE) begin
                r_dig <= w_digOn;
                if (w_enterActive) begin
                    r_seg <= w_pattern;
                end
            end else begin
                r_dig <= DIG_OFF;
                r_seg <= SEG_OFF;
            end
        end
    end

    assign seg7_o  = r_seg;
    assign dig_o   = r_dig;
    assign frame_o = r_frame;

endmodule
